// File: rtl/ex_wb_buf.sv
// EX -> MEM/WB pipeline register: resolves control transfers from the ALU flags,
// registers the fetch redirect and squashes the wrong-path slots that follow it.
module ex_wb_buf #(
    parameter int DATA_W        = 32,
    parameter int REG_W         = 6,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              valid_ex,
    input  logic [1:0]        writeBackControl_ex,
    input  logic              regWrt_ex,
    input  logic              memRead_ex,
    input  logic              memWrite_ex,
    input  logic              branchZero_ex,
    input  logic              branchNeg_ex,
    input  logic              jump_ex,
    input  logic              jumpMem_ex,
    input  logic              zero_ex,
    input  logic              neg_ex,
    input  logic [DATA_W-1:0] alu_result_ex,
    input  logic [DATA_W-1:0] pc_plus_y_ex,
    input  logic [DATA_W-1:0] xrs_ex,
    input  logic [DATA_W-1:0] xrt_ex,
    input  logic [REG_W-1:0]  rd_ex,
    output logic              valid_wb,
    output logic              regWrt_wb,
    output logic              memRead_wb,
    output logic              memWrite_wb,
    output logic [1:0]        writeBackControl_wb,
    output logic [DATA_W-1:0] alu_result_wb,
    output logic [DATA_W-1:0] xrt_wb,
    output logic [REG_W-1:0]  rd_wb,
    output logic              redirect_wb,
    output logic [1:0]        pc_src_wb,
    output logic [DATA_W-1:0] target_wb,
    output logic              squash_active
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

    state_t             state, state_nxt;
    logic [2:0]         cnt, cnt_nxt;
    logic               live;
    logic               taken;
    logic [1:0]         pc_src_nxt;
    logic [DATA_W-1:0]  target_nxt;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        live       = (state == RUN) && valid_ex;
        taken      = live && (jumpMem_ex | jump_ex | (branchZero_ex & zero_ex) | (branchNeg_ex & neg_ex));
        pc_src_nxt = 2'd0;
        target_nxt = '0;

        // Memory-indirect outranks register jump, which outranks a branch.
        if (taken) begin
            if (jumpMem_ex) begin
                pc_src_nxt = 2'd3;
                target_nxt = alu_result_ex;
            end else if (jump_ex) begin
                pc_src_nxt = 2'd2;
                target_nxt = xrs_ex;
            end else begin
                pc_src_nxt = 2'd1;
                target_nxt = pc_plus_y_ex;
            end
        end

        case (state)
            RUN: begin
                if (taken && (SQ_LOAD != 3'd0)) begin
                    state_nxt = SQUASH;
                    cnt_nxt   = SQ_LOAD;
                end
            end
            SQUASH: begin
                // Counts cycles, not instructions; transfers seen here never reload.
                if (cnt <= 3'd1) begin
                    state_nxt = RUN;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= RUN;
            cnt                 <= 3'd0;
            valid_wb            <= 1'b0;
            regWrt_wb           <= 1'b0;
            memRead_wb          <= 1'b0;
            memWrite_wb         <= 1'b0;
            writeBackControl_wb <= 2'd0;
            alu_result_wb       <= '0;
            xrt_wb              <= '0;
            rd_wb               <= '0;
            redirect_wb         <= 1'b0;
            pc_src_wb           <= 2'd0;
            target_wb           <= '0;
        end else if (!stall) begin
            state               <= state_nxt;
            cnt                 <= cnt_nxt;
            valid_wb            <= live;
            regWrt_wb           <= live & regWrt_ex;
            memRead_wb          <= live & memRead_ex;
            memWrite_wb         <= live & memWrite_ex;
            writeBackControl_wb <= writeBackControl_ex;
            alu_result_wb       <= alu_result_ex;
            xrt_wb              <= xrt_ex;
            rd_wb               <= rd_ex;
            redirect_wb         <= taken;
            pc_src_wb           <= pc_src_nxt;
            target_wb           <= target_nxt;
        end
    end

    assign squash_active = (state == SQUASH);

endmodule

// File: tb/tb_ex_wb_buf.sv
// Bench for ex_wb_buf: two builds (SQUASH_CYCLES = 2 and 0) driven in lockstep
// and compared against a cycle-level reference model of the redirect/squash rules.
module tb_ex_wb_buf;

  localparam int DATA_W = 32;
  localparam int REG_W  = 6;
  localparam int SQ     = 2;
  localparam int OBS_W  = 4 + 2 + DATA_W + DATA_W + REG_W + 1 + 2 + DATA_W + 1;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              stall, valid_ex, regWrt_ex, memRead_ex, memWrite_ex;
  logic              branchZero_ex, branchNeg_ex, jump_ex, jumpMem_ex, zero_ex, neg_ex;
  logic [1:0]        writeBackControl_ex;
  logic [DATA_W-1:0] alu_result_ex, pc_plus_y_ex, xrs_ex, xrt_ex;
  logic [REG_W-1:0]  rd_ex;

  logic              valid_wb, regWrt_wb, memRead_wb, memWrite_wb, redirect_wb, squash_active;
  logic [1:0]        writeBackControl_wb, pc_src_wb;
  logic [DATA_W-1:0] alu_result_wb, xrt_wb, target_wb;
  logic [REG_W-1:0]  rd_wb;

  logic              valid_wb0, regWrt_wb0, memRead_wb0, memWrite_wb0, redirect_wb0, squash_active0;
  logic [1:0]        writeBackControl_wb0, pc_src_wb0;
  logic [DATA_W-1:0] alu_result_wb0, xrt_wb0, target_wb0;
  logic [REG_W-1:0]  rd_wb0;

  logic [OBS_W-1:0]  obs, obs0;
  logic [OBS_W-1:0]  exp_q[$];
  logic [OBS_W-1:0]  exp0_q[$];

  int checks = 0;
  int errors = 0;

  int               m_left[2];
  int               m_sq[2];
  logic [OBS_W-1:0] m_out[2];

  always #5 clock = ~clock;

  ex_wb_buf #(.DATA_W(DATA_W), .REG_W(REG_W), .SQUASH_CYCLES(SQ)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .valid_ex(valid_ex),
    .writeBackControl_ex(writeBackControl_ex), .regWrt_ex(regWrt_ex),
    .memRead_ex(memRead_ex), .memWrite_ex(memWrite_ex),
    .branchZero_ex(branchZero_ex), .branchNeg_ex(branchNeg_ex),
    .jump_ex(jump_ex), .jumpMem_ex(jumpMem_ex), .zero_ex(zero_ex), .neg_ex(neg_ex),
    .alu_result_ex(alu_result_ex), .pc_plus_y_ex(pc_plus_y_ex), .xrs_ex(xrs_ex),
    .xrt_ex(xrt_ex), .rd_ex(rd_ex),
    .valid_wb(valid_wb), .regWrt_wb(regWrt_wb), .memRead_wb(memRead_wb),
    .memWrite_wb(memWrite_wb), .writeBackControl_wb(writeBackControl_wb),
    .alu_result_wb(alu_result_wb), .xrt_wb(xrt_wb), .rd_wb(rd_wb),
    .redirect_wb(redirect_wb), .pc_src_wb(pc_src_wb), .target_wb(target_wb),
    .squash_active(squash_active)
  );

  ex_wb_buf #(.DATA_W(DATA_W), .REG_W(REG_W), .SQUASH_CYCLES(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .stall(stall), .valid_ex(valid_ex),
    .writeBackControl_ex(writeBackControl_ex), .regWrt_ex(regWrt_ex),
    .memRead_ex(memRead_ex), .memWrite_ex(memWrite_ex),
    .branchZero_ex(branchZero_ex), .branchNeg_ex(branchNeg_ex),
    .jump_ex(jump_ex), .jumpMem_ex(jumpMem_ex), .zero_ex(zero_ex), .neg_ex(neg_ex),
    .alu_result_ex(alu_result_ex), .pc_plus_y_ex(pc_plus_y_ex), .xrs_ex(xrs_ex),
    .xrt_ex(xrt_ex), .rd_ex(rd_ex),
    .valid_wb(valid_wb0), .regWrt_wb(regWrt_wb0), .memRead_wb(memRead_wb0),
    .memWrite_wb(memWrite_wb0), .writeBackControl_wb(writeBackControl_wb0),
    .alu_result_wb(alu_result_wb0), .xrt_wb(xrt_wb0), .rd_wb(rd_wb0),
    .redirect_wb(redirect_wb0), .pc_src_wb(pc_src_wb0), .target_wb(target_wb0),
    .squash_active(squash_active0)
  );

  assign obs  = {valid_wb, regWrt_wb, memRead_wb, memWrite_wb, writeBackControl_wb,
                 alu_result_wb, xrt_wb, rd_wb, redirect_wb, pc_src_wb, target_wb, squash_active};
  assign obs0 = {valid_wb0, regWrt_wb0, memRead_wb0, memWrite_wb0, writeBackControl_wb0,
                 alu_result_wb0, xrt_wb0, rd_wb0, redirect_wb0, pc_src_wb0, target_wb0, squash_active0};

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0;
      m_out[k]  = '0;
    end
  endtask

  task automatic model_edge(input int k);
    logic              live, tk;
    logic [1:0]        src;
    logic [DATA_W-1:0] tgt;
    if (stall) return;
    live = (m_left[k] == 0) && valid_ex;
    tk   = live && (jumpMem_ex || jump_ex || (branchZero_ex && zero_ex) || (branchNeg_ex && neg_ex));
    src  = !tk ? 2'd0 : jumpMem_ex ? 2'd3 : jump_ex ? 2'd2 : 2'd1;
    case (src)
      2'd3:    tgt = alu_result_ex;
      2'd2:    tgt = xrs_ex;
      2'd1:    tgt = pc_plus_y_ex;
      default: tgt = '0;
    endcase
    if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
    if (tk) m_left[k] = m_sq[k];
    m_out[k] = {live, live & regWrt_ex, live & memRead_ex, live & memWrite_ex, writeBackControl_ex,
                alu_result_ex, xrt_ex, rd_ex, tk, src, tgt, (m_left[k] > 0)};
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    stall = 0; valid_ex = 0; writeBackControl_ex = 0;
    regWrt_ex = 0; memRead_ex = 0; memWrite_ex = 0;
    branchZero_ex = 0; branchNeg_ex = 0; jump_ex = 0; jumpMem_ex = 0;
    zero_ex = 0; neg_ex = 0;
    alu_result_ex = 0; pc_plus_y_ex = 0; xrs_ex = 0; xrt_ex = 0; rd_ex = 0;
  endtask

  task automatic drive_random(input bit allow_stall);
    stall = allow_stall && ($urandom_range(0, 4) == 0);
    valid_ex = ($urandom_range(0, 3) != 0);
    writeBackControl_ex = 2'($urandom_range(0, 3));
    regWrt_ex = 1'($urandom); memRead_ex = 1'($urandom); memWrite_ex = 1'($urandom);
    branchZero_ex = ($urandom_range(0, 4) == 0);
    branchNeg_ex  = ($urandom_range(0, 4) == 0);
    jump_ex       = ($urandom_range(0, 6) == 0);
    jumpMem_ex    = ($urandom_range(0, 8) == 0);
    zero_ex = 1'($urandom); neg_ex = 1'($urandom);
    alu_result_ex = $urandom; pc_plus_y_ex = $urandom; xrs_ex = $urandom; xrt_ex = $urandom;
    rd_ex = REG_W'($urandom_range(0, 63));
  endtask

  // One clock: model predicts, expectations are queued, outputs sampled 1 time unit later.
  task automatic step();
    for (int k = 0; k < 2; k++) model_edge(k);
    exp_q.push_back(m_out[0]);
    exp0_q.push_back(m_out[1]);
    @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [OBS_W-1:0] e, e0;
    reset_n = 0; stall = 1; valid_ex = 1; writeBackControl_ex = '1;
    regWrt_ex = 1; memRead_ex = 1; memWrite_ex = 1;
    branchZero_ex = 1; branchNeg_ex = 1; jump_ex = 1; jumpMem_ex = 1; zero_ex = 1; neg_ex = 1;
    alu_result_ex = '1; pc_plus_y_ex = '1; xrs_ex = '1; xrt_ex = '1; rd_ex = '1;
    model_reset();
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    checks++;
    if (obs0 !== '0) begin errors++; $display("FAIL reset_outputs_sq0: got %h expected 0", obs0); end
    checks++;
    if (squash_active !== 1'b0) begin errors++; $display("FAIL reset_squash: got %b expected 0", squash_active); end

    drive_idle();
    valid_ex = 1; regWrt_ex = 1; rd_ex = 6'd5; alu_result_ex = 32'h1234;
    reset_n = 1;
    step();
    e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    checks++;
    if (regWrt_wb !== 1'b1 || rd_wb !== 6'd5 || alu_result_wb !== 32'h1234 || redirect_wb !== 1'b0) begin
      errors++;
      $display("FAIL first_live: got rw=%b rd=%0d alu=%h redir=%b expected 1 5 1234 0",
               regWrt_wb, rd_wb, alu_result_wb, redirect_wb);
    end
    checks++;
    if (obs !== e) begin errors++; $display("FAIL first_live_model: got %h expected %h", obs, e); end
    checks++;
    if (obs0 !== e0) begin errors++; $display("FAIL first_live_sq0: got %h expected %h", obs0, e0); end
  endtask

  task automatic test_branch_zero();
    logic [OBS_W-1:0] e, e0;
    drive_idle();
    valid_ex = 1; branchZero_ex = 1; zero_ex = 1; pc_plus_y_ex = 32'h40;
    step();
    e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    checks++;
    if (redirect_wb !== 1'b1 || pc_src_wb !== 2'd1 || target_wb !== 32'h40 || squash_active !== 1'b1) begin
      errors++;
      $display("FAIL bz_taken: got redir=%b src=%0d tgt=%h sq=%b expected 1 1 40 1",
               redirect_wb, pc_src_wb, target_wb, squash_active);
    end
    checks++;
    if (obs !== e) begin errors++; $display("FAIL bz_taken_model: got %h expected %h", obs, e); end
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      valid_ex = 1; regWrt_ex = 1; rd_ex = REG_W'(10 + i); alu_result_ex = $urandom;
      step();
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      checks++;
      if (regWrt_wb !== (i == 2) || valid_wb !== (i == 2) || redirect_wb !== 1'b0) begin
        errors++;
        $display("FAIL bz_shadow%0d: got rw=%b v=%b redir=%b expected rw=v=%b redir=0",
                 i, regWrt_wb, valid_wb, redirect_wb, (i == 2));
      end
      checks++;
      if (obs !== e) begin errors++; $display("FAIL bz_shadow_model%0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_priority();
    logic [OBS_W-1:0] e, e0;
    drive_idle();
    valid_ex = 1; branchNeg_ex = 1; neg_ex = 0; pc_plus_y_ex = 32'h99;
    step();
    e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    checks++;
    if (redirect_wb !== 1'b0 || pc_src_wb !== 2'd0 || target_wb !== '0) begin
      errors++;
      $display("FAIL bn_not_taken: got redir=%b src=%0d tgt=%h expected 0 0 0", redirect_wb, pc_src_wb, target_wb);
    end
    drive_idle();
    valid_ex = 1; jumpMem_ex = 1; jump_ex = 1; branchZero_ex = 1; zero_ex = 1;
    alu_result_ex = 32'h80; xrs_ex = 32'h55; pc_plus_y_ex = 32'h66;
    step();
    e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    checks++;
    if (pc_src_wb !== 2'd3 || target_wb !== 32'h80 || redirect_wb !== 1'b1) begin
      errors++;
      $display("FAIL jm_priority: got src=%0d tgt=%h redir=%b expected 3 80 1", pc_src_wb, target_wb, redirect_wb);
    end
    checks++;
    if (obs0 !== e0) begin errors++; $display("FAIL jm_priority_sq0: got %h expected %h", obs0, e0); end
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      step();
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL jm_drain%0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_stall();
    logic [OBS_W-1:0] e, e0, snap;
    drive_idle();
    valid_ex = 1; jump_ex = 1; xrs_ex = 32'hABC0;
    step();
    e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    drive_idle();
    step();
    e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    snap = obs;
    checks++;
    if (obs !== e || squash_active !== 1'b1) begin
      errors++; $display("FAIL stall_pre: got %h expected %h", obs, e);
    end
    for (int i = 0; i < 3; i++) begin
      drive_random(1'b0);
      stall = 1;
      step();
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      checks++;
      if (obs !== snap || squash_active !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs, snap);
      end
      checks++;
      if (obs0 !== e0) begin errors++; $display("FAIL stall_hold_sq0%0d: got %h expected %h", i, obs0, e0); end
    end
    drive_idle();
    step();
    e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    checks++;
    if (squash_active !== 1'b0) begin errors++; $display("FAIL stall_release: got sq=%b expected 0", squash_active); end
    checks++;
    if (obs !== e) begin errors++; $display("FAIL stall_release_model: got %h expected %h", obs, e); end
  endtask

  task automatic test_ignored();
    logic [OBS_W-1:0] e, e0;
    drive_idle();
    valid_ex = 1; branchNeg_ex = 1; neg_ex = 1; pc_plus_y_ex = 32'h200;
    step();
    e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    drive_idle();
    valid_ex = 1; jump_ex = 1; xrs_ex = 32'h300;
    step();
    e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    checks++;
    if (redirect_wb !== 1'b0 || squash_active !== 1'b1 || valid_wb !== 1'b0) begin
      errors++;
      $display("FAIL ignored_jump: got redir=%b sq=%b v=%b expected 0 1 0", redirect_wb, squash_active, valid_wb);
    end
    drive_idle();
    step();
    e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    checks++;
    if (squash_active !== 1'b0) begin errors++; $display("FAIL ignored_schedule: got sq=%b expected 0", squash_active); end
    checks++;
    if (obs !== e) begin errors++; $display("FAIL ignored_model: got %h expected %h", obs, e); end

    valid_ex = 1; jump_ex = 1; xrs_ex = 32'h400;
    step();
    e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    reset_n = 0;
    #2;
    model_reset();
    checks++;
    if (squash_active !== 1'b0 || obs !== '0) begin
      errors++; $display("FAIL reset_mid_squash: got %h expected 0", obs);
    end
    reset_n = 1;
    drive_idle();
  endtask

  task automatic test_back_to_back_sq0();
    logic [OBS_W-1:0] e, e0;
    for (int i = 0; i < 2; i++) begin
      drive_idle();
      valid_ex = 1; jump_ex = 1; xrs_ex = 32'h1000 + 32'(i);
      step();
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      checks++;
      if (redirect_wb0 !== 1'b1 || target_wb0 !== 32'h1000 + 32'(i) || squash_active0 !== 1'b0) begin
        errors++;
        $display("FAIL sq0_jump%0d: got redir=%b tgt=%h sq=%b expected 1 %h 0",
                 i, redirect_wb0, target_wb0, squash_active0, 32'h1000 + 32'(i));
      end
      checks++;
      if (obs !== e) begin errors++; $display("FAIL sq0_main_model%0d: got %h expected %h", i, obs, e); end
    end
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      step();
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
    end
  endtask

  task automatic test_random();
    logic [OBS_W-1:0] e, e0;
    int bad = 0;
    int bad0 = 0;
    for (int i = 0; i < 600; i++) begin
      drive_random(1'b1);
      step();
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        if (bad < 5) $display("FAIL random_cyc%0d: got %h expected %h", i, obs, e);
        bad++;
      end
      checks++;
      if (obs0 !== e0) begin
        errors++;
        if (bad0 < 5) $display("FAIL random_sq0_cyc%0d: got %h expected %h", i, obs0, e0);
        bad0++;
      end
    end
  endtask

  initial begin
    m_sq[0] = SQ;
    m_sq[1] = 0;
    drive_idle();
    reset_n = 0;
    test_reset();
    test_branch_zero();
    test_priority();
    test_stall();
    test_ignored();
    test_back_to_back_sq0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
